// File: rtl/pc_gen.sv
// Fetch program-counter generator: IDLE/RUN/FLUSH FSM with post-jump bubbles and a fetch counter.
// Optional misaligned-jump rejection is enabled by defining PC_MISALIGN_CHK_EN.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module pc_gen #(
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned PC_STEP      = 4,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 work_ena,
    input  logic                 stall,
    input  logic                 pc_jump,
    input  logic [`PC_WIDTH-1:0] pc_target,
    output logic [`PC_WIDTH-1:0] pc_o,
    output logic                 fetch_valid_o,
    output logic                 flush_o,
    output logic [31:0]          fetch_cnt_o,
    output logic                 misalign_o
);

    localparam logic [`PC_WIDTH-1:0] RST_PC_V   = `PC_WIDTH'(RESET_PC);
    localparam logic [`PC_WIDTH-1:0] STEP_V     = `PC_WIDTH'(PC_STEP);
    localparam logic [`PC_WIDTH-1:0] ALIGN_MASK = `PC_WIDTH'(PC_STEP - 1);
    localparam logic [2:0]           FLUSH_V    = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [`PC_WIDTH-1:0] pc_q, pc_d;
    logic                 valid_q, valid_d;
    logic                 flush_q, flush_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [2:0]           fcnt_q, fcnt_d;
    logic                 mis_q, mis_d;

    logic                 jump_ok;
    logic                 jump_bad;
    logic [`PC_WIDTH-1:0] jump_pc;

`ifdef PC_MISALIGN_CHK_EN
    assign jump_ok  = pc_jump && ((pc_target & ALIGN_MASK) == '0);
    assign jump_bad = pc_jump && ((pc_target & ALIGN_MASK) != '0);
    assign jump_pc  = pc_target;
`else
    // Low bits are dropped so a misaligned target snaps down to the step boundary.
    assign jump_ok  = pc_jump;
    assign jump_bad = 1'b0;
    assign jump_pc  = pc_target & ~ALIGN_MASK;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        mis_d   = 1'b0;
        if (!work_ena) begin
            state_d = IDLE;
            pc_d    = RST_PC_V;
            valid_d = 1'b0;
            flush_d = 1'b0;
            cnt_d   = '0;
            fcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    pc_d    = RST_PC_V;
                    valid_d = 1'b1;
                    flush_d = 1'b0;
                end
                RUN, FLUSH: begin
                    mis_d = jump_bad;
                    if (jump_ok) begin
                        state_d = FLUSH;
                        pc_d    = jump_pc;
                        fcnt_d  = FLUSH_V;
                        valid_d = 1'b0;
                        flush_d = 1'b1;
                    end else if (!stall) begin
                        pc_d = pc_q + STEP_V;
                        if (valid_q)
                            cnt_d = cnt_q + 32'd1;
                        if (state_q == FLUSH) begin
                            fcnt_d = fcnt_q - 3'd1;
                            if (fcnt_q == 3'd1) begin
                                state_d = RUN;
                                flush_d = 1'b0;
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RST_PC_V;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            mis_q   <= mis_d;
        end
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = valid_q;
    assign flush_o       = flush_q;
    assign fetch_cnt_o   = cnt_q;
`ifdef PC_MISALIGN_CHK_EN
    assign misalign_o    = mis_q;
`else
    assign misalign_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Randomized + directed bench for pc_gen against a bubble-count reference model.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module tb_pc_gen;
    localparam int unsigned STEP = 4;
    localparam int unsigned NFL  = 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 work_ena = 1'b0;
    logic                 stall = 1'b0;
    logic                 pc_jump = 1'b0;
    logic [`PC_WIDTH-1:0] pc_target = '0;
    logic [`PC_WIDTH-1:0] pc_o;
    logic                 fetch_valid_o;
    logic                 flush_o;
    logic [31:0]          fetch_cnt_o;
    logic                 misalign_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: enabled flag, remaining bubbles, current pc and fetch count.
    bit                   m_en  = 0;
    int                   m_bub = 0;
    logic [`PC_WIDTH-1:0] m_pc  = '0;
    logic [31:0]          m_cnt = '0;
    bit                   m_mis = 0;

    pc_gen #(.RESET_PC(0), .PC_STEP(STEP), .FLUSH_CYCLES(NFL)) dut (
        .clk(clk), .rst(rst), .work_ena(work_ena), .stall(stall),
        .pc_jump(pc_jump), .pc_target(pc_target), .pc_o(pc_o),
        .fetch_valid_o(fetch_valid_o), .flush_o(flush_o),
        .fetch_cnt_o(fetch_cnt_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_bub = 0; m_pc = '0; m_cnt = '0; m_mis = 0;
    endtask

    task automatic model_edge(input bit we, input bit st, input bit jp,
                              input logic [`PC_WIDTH-1:0] tgt);
        bit misal;
        misal = (tgt % STEP) != 0;
        m_mis = 0;
        if (!we) begin
            model_reset();
        end else if (!m_en) begin
            m_en = 1;
        end else begin
`ifdef PC_MISALIGN_CHK_EN
            if (jp && misal) begin
                jp = 0;
                m_mis = 1;
            end
`endif
            if (jp) begin
                m_pc  = tgt - (tgt % STEP);
                m_bub = NFL;
            end else if (!st) begin
                m_pc = m_pc + STEP;
                if (m_bub > 0) m_bub--;
                else m_cnt++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc_o, m_pc);
        chk({tag, ".valid"}, fetch_valid_o, m_en && m_bub == 0);
        chk({tag, ".flush"}, flush_o, m_bub > 0);
        chk({tag, ".cnt"},   fetch_cnt_o, m_cnt);
        chk({tag, ".mis"},   misalign_o, m_mis);
    endtask

    task automatic step(input string tag, input bit we, input bit st, input bit jp,
                        input logic [`PC_WIDTH-1:0] tgt);
        work_ena = we; stall = st; pc_jump = jp; pc_target = tgt;
        @(posedge clk);
        model_edge(we, st, jp, tgt);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        #5 rst = 1'b0;
        @(negedge clk);

        // Start up and free run: 0,4,8,12,16 with count 4.
        step("start", 1, 0, 0, '0);
        chk("start_pc0", pc_o, 32'h0);
        for (int i = 0; i < 4; i++) step("run", 1, 0, 0, '0);
        chk("run_pc16", pc_o, 32'h10);
        chk("run_cnt4", fetch_cnt_o, 32'd4);

        // Stall 3 cycles at 0x10, then release.
        for (int i = 0; i < 3; i++) step("stall", 1, 1, 0, '0);
        chk("stall_hold", pc_o, 32'h10);
        step("unstall", 1, 0, 0, '0);
        chk("unstall_pc", pc_o, 32'h14);

        // Jump, bubble, then back-to-back jumps.
        step("jmp100", 1, 1, 1, 32'h100);
        chk("jmp100_flush", flush_o, 1'b1);
        step("after100", 1, 0, 0, '0);
        chk("after100_pc", pc_o, 32'h104);
        chk("after100_valid", fetch_valid_o, 1'b1);
        step("jmpA", 1, 0, 1, 32'h180);
        step("jmp200", 1, 0, 1, 32'h200);
        chk("jmp200_pc", pc_o, 32'h200);
        step("after200", 1, 0, 0, '0);

        // Wrap at the top of the address space.
        step("jmptop", 1, 0, 1, 32'hFFFF_FFF8);
        step("top1", 1, 0, 0, '0);
        chk("top1_pc", pc_o, 32'hFFFF_FFFC);
        step("wrap", 1, 0, 0, '0);
        chk("wrap_pc", pc_o, 32'h0);

        // Disable beats jump.
        step("disjmp", 0, 0, 1, 32'h300);
        chk("disjmp_pc", pc_o, 32'h0);
        step("restart", 1, 0, 1, 32'h300);
        chk("idle_jmp_ignored", pc_o, 32'h0);

        // Misaligned target.
        step("jmp102", 1, 0, 1, 32'h102);
`ifndef PC_MISALIGN_CHK_EN
        chk("jmp102_pc", pc_o, 32'h100);
`endif
        for (int i = 0; i < 3; i++) step("post102", 1, 0, 0, '0);

        // Async reset mid-run at 0x1C.
        step("dis", 0, 0, 0, '0);
        for (int i = 0; i < 8; i++) step("to1c", 1, 0, 0, '0);
        chk("pre_rst_pc", pc_o, 32'h1C);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #1 rst = 1'b0;
        @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit we, st, jp;
            logic [`PC_WIDTH-1:0] tgt;
            we  = ($urandom_range(0, 99) < 95);
            st  = ($urandom_range(0, 99) < 25);
            jp  = ($urandom_range(0, 99) < 15);
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            step("rand", we, st, jp, tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
